// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: EX-stage branch resolution and mispredict recovery.
// Resolves conditional branches, JAL and JALR against the fetch prediction,
// issues a redirect handshake to fetch, then holds a bounded IF/ID flush.
// Optional macro BRANCH_PERF_EN enables the branch/mispredict counters;
// without it the perf ports are tied to zero.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | accepting EX control-flow instructions
// REDIRECT | redirect held to fetch until redir_ready, flushing
// FLUSH    | post-handshake flush hold, FLUSH_CYCLES cycles
module branch_resolve_ctrl #(
    parameter int N            = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ex_valid,
    output logic         ex_ready,
    input  logic         ex_is_branch,
    input  logic         ex_is_jal,
    input  logic         ex_is_jalr,
    input  logic [2:0]   ex_funct3,
    input  logic         ex_pred_taken,
    input  logic [N-1:0] ex_pc,
    input  logic [N-1:0] ex_imm,
    input  logic [N-1:0] ex_rs1,
    output logic         br_un,
    input  logic         br_eq,
    input  logic         br_lt,
    output logic         redir_valid,
    input  logic         redir_ready,
    output logic [N-1:0] redir_pc,
    output logic         flush,
    output logic [31:0]  perf_branches,
    output logic [31:0]  perf_mispredicts
);

    localparam int CW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
    localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_REDIRECT = 2'd1;
    localparam logic [1:0] ST_FLUSH    = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  redir_pc_q, redir_pc_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          cond;
    logic          taken;
    logic          cf_accept;
    logic          mispredict;
    logic [N-1:0]  target;
    logic [N-1:0]  correct_pc;

    // Comparator signedness follows funct3 bit 1 (BLTU/BGEU) at all times.
    assign br_un = ex_funct3[1];

    // Branch condition decode from same-cycle comparator results.
    always_comb begin
        cond = 1'b0;
        case (ex_funct3)
            3'b000:         cond = br_eq;
            3'b001:         cond = ~br_eq;
            3'b100, 3'b110: cond = br_lt;
            3'b101, 3'b111: cond = ~br_lt;
            default:        cond = 1'b0;
        endcase
    end

    // Resolution: taken decision, target, and mispredict detection.
    always_comb begin
        taken      = ex_is_jal | ex_is_jalr | (ex_is_branch & cond);
        if (ex_is_jalr) begin
            target = (ex_rs1 + ex_imm) & {{(N-1){1'b1}}, 1'b0};
        end else begin
            target = ex_pc + ex_imm;
        end
        correct_pc = taken ? target : (ex_pc + N'(4));
        cf_accept  = ex_valid & ex_ready & (ex_is_branch | ex_is_jal | ex_is_jalr);
        // JALR target is never predicted by fetch, so it always redirects.
        mispredict = cf_accept & (ex_is_jalr | (taken != ex_pred_taken));
    end

    // Next-state logic for the redirect/flush sequencer.
    always_comb begin
        state_d    = state_q;
        redir_pc_d = redir_pc_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (mispredict) begin
                    redir_pc_d = correct_pc;
                    state_d    = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                if (redir_ready) begin
                    if (FLUSH_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FLUSH;
                        cnt_d   = FLUSH_LOAD;
                    end
                end
            end
            ST_FLUSH: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, held redirect PC and flush down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            redir_pc_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            redir_pc_q <= redir_pc_d;
            cnt_q      <= cnt_d;
        end
    end

    // Outputs decode directly from state so reset clears them without a clock.
    always_comb begin
        ex_ready    = (state_q == ST_IDLE);
        redir_valid = (state_q == ST_REDIRECT);
        flush       = (state_q != ST_IDLE);
        redir_pc    = redir_pc_q;
    end

`ifdef BRANCH_PERF_EN
    logic [31:0] perf_br_q, perf_br_d;
    logic [31:0] perf_mp_q, perf_mp_d;

    // Saturating event counters.
    always_comb begin
        perf_br_d = perf_br_q;
        perf_mp_d = perf_mp_q;
        if (cf_accept && (perf_br_q != 32'hFFFF_FFFF)) begin
            perf_br_d = perf_br_q + 32'd1;
        end
        if (mispredict && (perf_mp_q != 32'hFFFF_FFFF)) begin
            perf_mp_d = perf_mp_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_br_q <= '0;
            perf_mp_q <= '0;
        end else begin
            perf_br_q <= perf_br_d;
            perf_mp_q <= perf_mp_d;
        end
    end

    assign perf_branches    = perf_br_q;
    assign perf_mispredicts = perf_mp_q;
`else
    assign perf_branches    = 32'd0;
    assign perf_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: vector table plus hand sequences
// for handshake timing, stall, back-pressure and asynchronous reset.
module tb_branch_resolve_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_is_branch;
    logic        ex_is_jal;
    logic        ex_is_jalr;
    logic [2:0]  ex_funct3;
    logic        ex_pred_taken;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_rs1;
    logic        br_un;
    logic        br_eq;
    logic        br_lt;
    logic        redir_valid;
    logic        redir_ready;
    logic [31:0] redir_pc;
    logic        flush;
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;

    int errors = 0;
    int checks = 0;
    int exp_br = 0;
    int exp_mp = 0;

    branch_resolve_ctrl #(.N(32), .FLUSH_CYCLES(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_valid         (ex_valid),
        .ex_ready         (ex_ready),
        .ex_is_branch     (ex_is_branch),
        .ex_is_jal        (ex_is_jal),
        .ex_is_jalr       (ex_is_jalr),
        .ex_funct3        (ex_funct3),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pc            (ex_pc),
        .ex_imm           (ex_imm),
        .ex_rs1           (ex_rs1),
        .br_un            (br_un),
        .br_eq            (br_eq),
        .br_lt            (br_lt),
        .redir_valid      (redir_valid),
        .redir_ready      (redir_ready),
        .redir_pc         (redir_pc),
        .flush            (flush),
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        br, jal, jalr;
        logic [2:0]  f3;
        logic        pred, eq, lt;
        logic [31:0] pc, imm, rs1;
        logic        exp_un;
        logic        exp_redir;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                         input logic pred, input logic eq, input logic lt,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1);
        ex_is_branch  = br;
        ex_is_jal     = jal;
        ex_is_jalr    = jalr;
        ex_funct3     = f3;
        ex_pred_taken = pred;
        br_eq         = eq;
        br_lt         = lt;
        ex_pc         = pc;
        ex_imm        = imm;
        ex_rs1        = rs1;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 10 && !ex_ready; i++) @(negedge clk);
        chk({name, "_idle"}, {31'd0, ex_ready}, 32'd1);
    endtask

    initial begin
        //                 name      br jal jalr f3      pred eq lt pc            imm           rs1          un redir exp_pc
        vecs[0]  = '{"beq_t",   1, 0, 0, 3'b000, 0, 1, 0, 32'h100,      32'h20,       32'h0,    0, 1, 32'h120};
        vecs[1]  = '{"bltu_ok", 1, 0, 0, 3'b110, 1, 0, 1, 32'h300,      32'h40,       32'h0,    1, 0, 32'h0};
        vecs[2]  = '{"blt_ok",  1, 0, 0, 3'b100, 1, 0, 1, 32'h300,      32'h40,       32'h0,    0, 0, 32'h0};
        vecs[3]  = '{"bne_nt",  1, 0, 0, 3'b001, 1, 1, 0, 32'h200,      32'h40,       32'h0,    0, 1, 32'h204};
        vecs[4]  = '{"jalr",    0, 0, 1, 3'b000, 1, 0, 0, 32'h0,        32'h4,        32'h1003, 0, 1, 32'h1006};
        vecs[5]  = '{"jal_wrap",0, 1, 0, 3'b000, 0, 0, 0, 32'hFFFFFFF0, 32'h20,       32'h0,    0, 1, 32'h10};
        vecs[6]  = '{"bge_t",   1, 0, 0, 3'b101, 0, 0, 0, 32'h400,      32'hFFFFFFF0, 32'h0,    0, 1, 32'h3F0};
        vecs[7]  = '{"bgeu_nt", 1, 0, 0, 3'b111, 0, 0, 1, 32'h400,      32'h80,       32'h0,    1, 0, 32'h0};
        vecs[8]  = '{"f3_010",  1, 0, 0, 3'b010, 1, 1, 1, 32'h500,      32'h80,       32'h0,    1, 1, 32'h504};
        vecs[9]  = '{"no_cf",   0, 0, 0, 3'b000, 1, 1, 1, 32'h600,      32'h80,       32'h0,    0, 0, 32'h0};
        vecs[10] = '{"jal_ok",  0, 1, 0, 3'b000, 1, 0, 0, 32'h10,       32'h8,        32'h0,    0, 0, 32'h0};

        rst_n = 1'b0;
        ex_valid = 1'b0;
        redir_ready = 1'b0;
        drive(0, 0, 0, 3'b000, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        #2;
        chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
        chk("rst_redir_valid", {31'd0, redir_valid}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_redir_pc", redir_pc, 32'd0);
        chk("rst_perf_br", perf_branches, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Exact handshake/flush timing for a taken BEQ predicted not-taken.
        drive(1, 0, 0, 3'b000, 0, 1, 0, 32'h100, 32'h20, 32'h0);
        ex_valid = 1'b1;
        exp_br++; exp_mp++;
        @(negedge clk);
        ex_valid = 1'b0;
        chk("seq1_c1_redir_valid", {31'd0, redir_valid}, 32'd1);
        chk("seq1_c1_redir_pc", redir_pc, 32'h120);
        chk("seq1_c1_flush", {31'd0, flush}, 32'd1);
        chk("seq1_c1_ex_ready", {31'd0, ex_ready}, 32'd0);
        redir_ready = 1'b1;
        @(negedge clk);
        redir_ready = 1'b0;
        chk("seq1_c2_redir_valid", {31'd0, redir_valid}, 32'd0);
        chk("seq1_c2_flush", {31'd0, flush}, 32'd1);
        chk("seq1_c2_ex_ready", {31'd0, ex_ready}, 32'd0);
        @(negedge clk);
        chk("seq1_c3_flush", {31'd0, flush}, 32'd1);
        chk("seq1_c3_ex_ready", {31'd0, ex_ready}, 32'd0);
        @(negedge clk);
        chk("seq1_c4_flush", {31'd0, flush}, 32'd0);
        chk("seq1_c4_ex_ready", {31'd0, ex_ready}, 32'd1);

        // Vector table: each entry accepted from IDLE, redirect drained if raised.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].br, vecs[i].jal, vecs[i].jalr, vecs[i].f3, vecs[i].pred,
                  vecs[i].eq, vecs[i].lt, vecs[i].pc, vecs[i].imm, vecs[i].rs1);
            ex_valid = 1'b1;
            if (vecs[i].br || vecs[i].jal || vecs[i].jalr) exp_br++;
            if (vecs[i].exp_redir) exp_mp++;
            #1;
            chk({vecs[i].name, "_br_un"}, {31'd0, br_un}, {31'd0, vecs[i].exp_un});
            chk({vecs[i].name, "_ex_ready"}, {31'd0, ex_ready}, 32'd1);
            @(negedge clk);
            ex_valid = 1'b0;
            chk({vecs[i].name, "_redir_valid"}, {31'd0, redir_valid}, {31'd0, vecs[i].exp_redir});
            if (vecs[i].exp_redir) begin
                chk({vecs[i].name, "_redir_pc"}, redir_pc, vecs[i].exp_pc);
                redir_ready = 1'b1;
                @(negedge clk);
                redir_ready = 1'b0;
                wait_idle(vecs[i].name);
            end else begin
                chk({vecs[i].name, "_no_flush"}, {31'd0, flush}, 32'd0);
            end
        end

        // Fetch stalls the redirect; a new instruction offered meanwhile is ignored.
        drive(1, 0, 0, 3'b001, 1, 1, 0, 32'h200, 32'h40, 32'h0);
        ex_valid = 1'b1;
        exp_br++; exp_mp++;
        @(negedge clk);
        drive(0, 1, 0, 3'b000, 0, 0, 0, 32'h800, 32'h100, 32'h0);
        for (int c = 0; c < 3; c++) begin
            chk("stall_redir_valid", {31'd0, redir_valid}, 32'd1);
            chk("stall_redir_pc", redir_pc, 32'h204);
            chk("stall_ex_ready", {31'd0, ex_ready}, 32'd0);
            @(negedge clk);
        end
        ex_valid = 1'b0;
        chk("stall_end_redir_pc", redir_pc, 32'h204);
        redir_ready = 1'b1;
        @(negedge clk);
        redir_ready = 1'b0;
        chk("stall_hs_redir_valid", {31'd0, redir_valid}, 32'd0);
        wait_idle("stall");
        @(negedge clk);
        chk("stall_no_requeue", {31'd0, redir_valid}, 32'd0);

`ifdef BRANCH_PERF_EN
        chk("perf_branches", perf_branches, 32'(exp_br));
        chk("perf_mispredicts", perf_mispredicts, 32'(exp_mp));
`else
        chk("perf_branches_tied", perf_branches, 32'd0);
        chk("perf_mispredicts_tied", perf_mispredicts, 32'd0);
`endif

        // Asynchronous reset while in FLUSH drops the sequence immediately.
        drive(0, 1, 0, 3'b000, 0, 0, 0, 32'h40, 32'h10, 32'h0);
        ex_valid = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0;
        redir_ready = 1'b1;
        @(negedge clk);
        redir_ready = 1'b0;
        chk("pre_rst_flush", {31'd0, flush}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_flush", {31'd0, flush}, 32'd0);
        chk("arst_redir_valid", {31'd0, redir_valid}, 32'd0);
        chk("arst_ex_ready", {31'd0, ex_ready}, 32'd1);
        chk("arst_redir_pc", redir_pc, 32'd0);
        chk("arst_perf_mp", perf_mispredicts, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {31'd0, flush}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
